// File: rtl/add_serial_seq.sv
// add_serial_seq: bit-serial add sequencer.
// A WIDTH-bit operand pair is latched on accept and summed one bit per cycle
// (LSB first) through a single full-adder stage with a registered carry.
// The completed sum and carry-out are published once, when SHIFT ends.
// Optional feature macro: ADD_SERIAL_SEQ_SUB_EN adds the 'sub' port (A - B).
module add_serial_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADD_SERIAL_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Counter needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             carry_out_r;
    logic [CW-1:0]    cnt_r;

    logic             accept_s;
    logic             last_step_s;
    logic             bit_sum_s;
    logic             bit_carry_s;
    logic [WIDTH-1:0] res_next_s;
    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;

    // One-bit full adder: sum output.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // One-bit full adder: carry output.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | ((x ^ y) & ci);
    endfunction

    assign accept_s    = (state_r == ST_IDLE) && start;
    assign last_step_s = (cnt_r == CW'(WIDTH - 1));
    assign bit_sum_s   = fa_sum(a_r[0], b_r[0], carry_r);
    assign bit_carry_s = fa_carry(a_r[0], b_r[0], carry_r);

    // Operand B / carry selection at accept; subtraction is A + ~B + 1.
`ifdef ADD_SERIAL_SEQ_SUB_EN
    assign b_load_s = sub ? ~b : b;
    assign c_load_s = sub ? 1'b1 : carry_in;
`else
    assign b_load_s = b;
    assign c_load_s = carry_in;
`endif

    // New result bit enters at the MSB; earlier bits move toward the LSB.
    always_comb begin
        res_next_s            = res_r >> 1;
        res_next_s[WIDTH-1]   = bit_sum_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_step_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand latch on accept, one bit step per SHIFT cycle,
    // and result publication on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            cnt_r       <= {CW{1'b0}};
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b_load_s;
            carry_r <= c_load_s;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            a_r     <= a_r >> 1;
            b_r     <= b_r >> 1;
            carry_r <= bit_carry_s;
            res_r   <= res_next_s;
            cnt_r   <= cnt_r + CW'(1);
            if (last_step_s) begin
                sum_r       <= res_next_s;
                carry_out_r <= bit_carry_s;
            end
        end
    end

    assign ready     = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_SHIFT);
    assign done      = (state_r == ST_DONE);
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

endmodule

// File: tb/tb_add_serial_seq.sv
// Self-checking bench for add_serial_seq (WIDTH=4). Expected results come from
// plain integer arithmetic; define ADD_SERIAL_SEQ_SUB_EN to exercise 'sub'.
module tb_add_serial_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
`ifdef ADD_SERIAL_SEQ_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int           n_checks;
    int           n_errors;
    logic [W-1:0] prev_sum;
    logic         prev_co;

    add_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef ADD_SERIAL_SEQ_SUB_EN
        .sub       (sub),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_sum"},   32'(sum),   32'd0);
        chk({tag, "_co"},    32'(carry_out), 32'd0);
    endtask

    // Reference: {carry_out, sum} of A + (B or ~B) + carry, modulo 2^W.
    function automatic logic [W:0] ref_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic tc, input logic ts);
        int unsigned bb;
        int unsigned cc;
        int unsigned tot;
        bb  = ts ? ((1 << W) - 1 - int'(tb)) : int'(tb);
        cc  = ts ? 1 : int'(tc);
        tot = int'(ta) + bb + cc;
        return (W + 1)'(tot);
    endfunction

    // Launch one operation from an IDLE negedge and check latency and result.
    // Operands are scrambled right after accept to show they are not re-sampled.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input string tag);
        logic [W:0] exp_v;
        int         k;
        bit         found;
        exp_v = ref_op(ta, tb, tc, ts);
        chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
        a = ta; b = tb; carry_in = tc; start = 1'b1;
`ifdef ADD_SERIAL_SEQ_SUB_EN
        sub = ts;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
`ifdef ADD_SERIAL_SEQ_SUB_EN
        sub = 1'($urandom);
`endif
        k = 0;
        found = 1'b0;
        while (!found && k < 3 * W + 8) begin
            @(negedge clk);
            k++;
            if (done) begin
                found = 1'b1;
            end else if (k == 1) begin
                chk({tag, "_busy"},     32'(busy),  32'd1);
                chk({tag, "_ready_b"},  32'(ready), 32'd0);
                chk({tag, "_sum_hold"}, 32'(sum),   32'(prev_sum));
            end
        end
        chk({tag, "_latency"}, 32'(k), 32'(W + 1));
        chk({tag, "_sum"}, 32'(sum), 32'(exp_v[W-1:0]));
        chk({tag, "_co"},  32'(carry_out), 32'(exp_v[W]));
        prev_sum = exp_v[W-1:0];
        prev_co  = exp_v[W];
        @(negedge clk);
        chk({tag, "_ready_post"}, 32'(ready), 32'd1);
        chk({tag, "_done_post"},  32'(done),  32'd0);
        chk({tag, "_sum_keep"},   32'(sum),   32'(prev_sum));
    endtask

    initial begin
        int         ndone;
        int         idx;
        int         d_idx [2];
        logic [W:0] d_val [2];
        logic [W:0] rexp;

        n_checks = 0;
        n_errors = 0;
        prev_sum = '0;
        prev_co  = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
`ifdef ADD_SERIAL_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        // Directed cases.
        run_op(4'd7,  4'd5, 1'b0, 1'b0, "add7_5");
        run_op(4'd15, 4'd1, 1'b0, 1'b0, "wrap15_1");
        run_op(4'd9,  4'd6, 1'b1, 1'b0, "wrap9_6_c");

        // start pulsed mid-SHIFT must be ignored.
        a = 4'd2; b = 4'd2; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_sum_hold", 32'(sum), 32'(prev_sum));
        a = 4'd3; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("mid_sum", 32'(sum), 32'd4);
                chk("mid_co",  32'(carry_out), 32'd0);
            end
        end
        chk("mid_ndone", 32'(ndone), 32'd1);
        chk("mid_ready", 32'(ready), 32'd1);
        prev_sum = 4'd4;
        prev_co  = 1'b0;

        // Reset asserted on the second SHIFT cycle.
        a = 4'd10; b = 4'd4; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rmid");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rmid_ndone", 32'(ndone), 32'd0);
        chk_reset_outputs("rmid_after");
        prev_sum = '0;
        prev_co  = 1'b0;
        run_op(4'd1, 4'd1, 1'b0, 1'b0, "post_rst");

        // start held high: back-to-back 1+2 then 4+4.
        a = 4'd1; b = 4'd2; carry_in = 1'b0; start = 1'b1;
        ndone = 0;
        idx = 0;
        while (ndone < 2 && idx < 40) begin
            @(negedge clk);
            idx++;
            if (idx == 1) begin
                a = 4'd4; b = 4'd4;
            end
            if (done) begin
                d_idx[ndone] = idx;
                d_val[ndone] = {carry_out, sum};
                ndone++;
                if (ndone == 2) start = 1'b0;
            end
        end
        chk("b2b_ndone", 32'(ndone), 32'd2);
        chk("b2b_gap", 32'(d_idx[1] - d_idx[0]), 32'(W + 2));
        chk("b2b_first", 32'(d_val[0]), 32'd3);
        chk("b2b_second", 32'(d_val[1]), 32'd8);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", 32'(ready), 32'd1);
        prev_sum = 4'd8;
        prev_co  = 1'b0;

`ifdef ADD_SERIAL_SEQ_SUB_EN
        run_op(4'd3, 4'd5, 1'b0, 1'b1, "sub3_5");
        run_op(4'd5, 4'd3, 1'b1, 1'b1, "sub5_3");
        run_op(4'd5, 4'd3, 1'b0, 1'b0, "add5_3");
`endif

        // Randomized operations against the reference.
        for (int i = 0; i < 30; i++) begin
            logic ts;
`ifdef ADD_SERIAL_SEQ_SUB_EN
            ts = 1'($urandom);
`else
            ts = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), ts, "rnd");
        end

        // Sanity of the reference itself against hand-derived values.
        rexp = ref_op(4'd9, 4'd6, 1'b1, 1'b0);
        chk("ref_wrap", 32'(rexp), 32'd16);
        chk("final_co", 32'(carry_out), 32'(prev_co));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
